// File: rtl/unidade_load_store_if.sv
// Execute-stage request/response channel plus the word-addressed data memory port of the
// load/store unit. The master modport is the requester/memory side, slave is the unit itself.
interface unidade_load_store_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_escrita;
    logic [1:0]  req_tamanho;
    logic        req_sinal;
    logic [31:0] req_endereco;
    logic [31:0] req_dado;

    logic        resp_valid;
    logic [31:0] resp_dado;
    logic        resp_erro;

    logic [31:0] mem_endereco;
    logic [31:0] mem_dado_wrt;
    logic        mem_controle;
    logic [31:0] mem_saida_dado;

    modport master (
        output req_valid,
        output req_escrita,
        output req_tamanho,
        output req_sinal,
        output req_endereco,
        output req_dado,
        output mem_saida_dado,
        input  req_ready,
        input  resp_valid,
        input  resp_dado,
        input  resp_erro,
        input  mem_endereco,
        input  mem_dado_wrt,
        input  mem_controle
    );

    modport slave (
        input  req_valid,
        input  req_escrita,
        input  req_tamanho,
        input  req_sinal,
        input  req_endereco,
        input  req_dado,
        input  mem_saida_dado,
        output req_ready,
        output resp_valid,
        output resp_dado,
        output resp_erro,
        output mem_endereco,
        output mem_dado_wrt,
        output mem_controle
    );
endinterface

// File: rtl/unidade_load_store.sv
// Load/store unit in front of a word-only data memory: sub-word stores as read-modify-write.
// Optional macro LSU_TRAP_DESALINHADO_EN turns misaligned halfword/word accesses into errors.
module unidade_load_store #(
    parameter int unsigned PROFUNDIDADE = 21
) (
    input logic                 clock,
    input logic                 reset_n,
    unidade_load_store_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StAcesso,
        StEscrita,
        StResp,
        StErroResp
    } estado_t;

    estado_t     estado_q;
    logic        escrita_q;
    logic [1:0]  tamanho_q;
    logic        sinal_q;
    logic [31:0] endereco_q;
    logic [31:0] dado_q;

    logic [31:0] mem_endereco_q;
    logic [31:0] mem_dado_wrt_q;
    logic        mem_controle_q;
    logic        resp_valid_q;
    logic        resp_erro_q;
    logic [31:0] resp_dado_q;

    logic        desalinhado;
    logic        fora_faixa;
    logic        erro;

    // Replace the addressed lanes of the read word with the low bits of the store data.
    function automatic logic [31:0] mesclar(input logic [31:0] base,
                                            input logic [31:0] dado,
                                            input logic [1:0]  tamanho,
                                            input logic [1:0]  lane);
        logic [31:0] r;
        r = base;
        case (tamanho)
            2'b00:   r[{lane, 3'b000} +: 8] = dado[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = dado[15:0];
            2'b10:   r = dado;
            default: r = base;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extrair(input logic [31:0] palavra,
                                            input logic [1:0]  tamanho,
                                            input logic [1:0]  lane,
                                            input logic        sinal);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = palavra[{lane, 3'b000} +: 8];
        h = palavra[{lane[1], 4'b0000} +: 16];
        case (tamanho)
            2'b00:   r = {{24{sinal & b[7]}}, b};
            2'b01:   r = {{16{sinal & h[15]}}, h};
            2'b10:   r = palavra;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always_comb begin
        desalinhado = 1'b0;
`ifdef LSU_TRAP_DESALINHADO_EN
        case (tamanho_q)
            2'b01:   desalinhado = endereco_q[0];
            2'b10:   desalinhado = |endereco_q[1:0];
            default: desalinhado = 1'b0;
        endcase
`else
        // Lane selection already ignores the bits below the access size.
        desalinhado = 1'b0;
`endif
        fora_faixa = ({2'b00, endereco_q[31:2]} >= PROFUNDIDADE);
        erro       = fora_faixa || (tamanho_q == 2'b11) || desalinhado;
    end

    // Merge and load extraction use the memory read directly at the ACESSO edge; the
    // registered results act as the read latch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q       <= StIdle;
            escrita_q      <= 1'b0;
            tamanho_q      <= 2'b00;
            sinal_q        <= 1'b0;
            endereco_q     <= 32'h0;
            dado_q         <= 32'h0;
            mem_endereco_q <= 32'h0;
            mem_dado_wrt_q <= 32'h0;
            mem_controle_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_erro_q    <= 1'b0;
            resp_dado_q    <= 32'h0;
        end else begin
            mem_dado_wrt_q <= 32'h0;
            mem_controle_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_erro_q    <= 1'b0;
            resp_dado_q    <= 32'h0;
            case (estado_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        escrita_q      <= bus.req_escrita;
                        tamanho_q      <= bus.req_tamanho;
                        sinal_q        <= bus.req_sinal;
                        endereco_q     <= bus.req_endereco;
                        dado_q         <= bus.req_dado;
                        mem_endereco_q <= {2'b00, bus.req_endereco[31:2]};
                        estado_q       <= StAcesso;
                    end
                end
                StAcesso: begin
                    if (erro) begin
                        estado_q     <= StErroResp;
                        resp_valid_q <= 1'b1;
                        resp_erro_q  <= 1'b1;
                    end else if (escrita_q) begin
                        estado_q       <= StEscrita;
                        mem_controle_q <= 1'b1;
                        mem_dado_wrt_q <= mesclar(bus.mem_saida_dado, dado_q, tamanho_q,
                                                  endereco_q[1:0]);
                    end else begin
                        estado_q     <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_dado_q  <= extrair(bus.mem_saida_dado, tamanho_q,
                                                endereco_q[1:0], sinal_q);
                    end
                end
                StEscrita: begin
                    estado_q     <= StResp;
                    resp_valid_q <= 1'b1;
                end
                StResp:     estado_q <= StIdle;
                StErroResp: estado_q <= StIdle;
                default:    estado_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready    = (estado_q == StIdle);
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_erro    = resp_erro_q;
    assign bus.resp_dado    = resp_dado_q;
    assign bus.mem_endereco = mem_endereco_q;
    assign bus.mem_dado_wrt = mem_dado_wrt_q;
    // Gated so that an edge sampling reset never writes memory.
    assign bus.mem_controle = mem_controle_q & reset_n;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed vector bench for unidade_load_store with a 21-word behavioural data memory.
module tb_unidade_load_store;

    logic clock;
    logic reset_n;
    logic mem_clear;

    unidade_load_store_if bus ();

    unidade_load_store #(.PROFUNDIDADE(21)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [0:31];

    assign bus.mem_saida_dado = (bus.mem_endereco < 32'd21) ? mem[bus.mem_endereco[4:0]] : 32'h0;

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (bus.mem_controle && bus.mem_endereco < 32'd21) begin
            mem[bus.mem_endereco[4:0]] <= bus.mem_dado_wrt;
        end
    end

    int n_cmp;
    int n_err;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    typedef struct {
        logic        escrita;
        logic [1:0]  tam;
        logic        sinal;
        logic [31:0] endr;
        logic [31:0] dado;
        logic [31:0] exp_dado;
        logic        exp_erro;
        int          chk_idx;
        logic [31:0] exp_mem;
    } vec_t;

    function automatic vec_t mk(input logic escrita, input logic [1:0] tam, input logic sinal,
                                input logic [31:0] endr, input logic [31:0] dado,
                                input logic [31:0] exp_dado, input logic exp_erro,
                                input int chk_idx, input logic [31:0] exp_mem);
        vec_t v;
        v.escrita  = escrita;
        v.tam      = tam;
        v.sinal    = sinal;
        v.endr     = endr;
        v.dado     = dado;
        v.exp_dado = exp_dado;
        v.exp_erro = exp_erro;
        v.chk_idx  = chk_idx;
        v.exp_mem  = exp_mem;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input int k);
        bit          got;
        int          lat;
        int          wr;
        logic [31:0] dado;
        logic        erro;
        int          exp_lat;
        int          exp_wr;
        string       tag;
        tag = $sformatf("v%0d", k);
        got = 0; lat = 0; wr = 0; dado = 32'h0; erro = 1'b0;
        for (int c = 0; c < 8 && !bus.req_ready; c++) @(negedge clock);
        chk({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid    = 1'b1;
        bus.req_escrita  = v.escrita;
        bus.req_tamanho  = v.tam;
        bus.req_sinal    = v.sinal;
        bus.req_endereco = v.endr;
        bus.req_dado     = v.dado;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (!got) begin
                if (bus.mem_controle) wr++;
                if (bus.resp_valid) begin
                    got  = 1;
                    lat  = c;
                    dado = bus.resp_dado;
                    erro = bus.resp_erro;
                end else begin
                    @(posedge clock); #1;
                end
            end
        end
        exp_lat = v.exp_erro ? 2 : (v.escrita ? 3 : 2);
        exp_wr  = (v.escrita && !v.exp_erro) ? 1 : 0;
        chk({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_resp_dado"}, dado, v.exp_dado);
        chk({tag, "_resp_erro"}, {31'h0, erro}, {31'h0, v.exp_erro});
        chk({tag, "_writes"}, wr, exp_wr);
        if (v.chk_idx >= 0) chk({tag, "_mem"}, mem[v.chk_idx], v.exp_mem);
    endtask

    vec_t vecs[$];

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.req_valid    = 1'b0;
        bus.req_escrita  = 1'b0;
        bus.req_tamanho  = 2'b00;
        bus.req_sinal    = 1'b0;
        bus.req_endereco = 32'h0;
        bus.req_dado     = 32'h0;
        reset_n   = 1'b0;
        mem_clear = 1'b1;

        //             wr  tam    sx  addr    data          exp_dado      err idx exp_mem
        vecs.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0,        0, 2,  32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0, -1, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h04, 32'h11223344, 32'h0,        0, 1,  32'h11223344));
        vecs.push_back(mk(1, 2'b00, 0, 32'h06, 32'h123456AA, 32'h0,        0, 1,  32'h11AA3344));
        vecs.push_back(mk(0, 2'b00, 1, 32'h06, 32'h0,        32'hFFFFFFAA, 0, -1, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h06, 32'h0,        32'h000000AA, 0, -1, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h02, 32'hFFFF8001, 32'h0,        0, 0,  32'h80010000));
        vecs.push_back(mk(0, 2'b01, 1, 32'h02, 32'h0,        32'hFFFF8001, 0, -1, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h02, 32'h0,        32'h00008001, 0, -1, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h54, 32'h55555555, 32'h0,        1, -1, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h04, 32'h0,        32'h0,        1, -1, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 32'h0,        0, 20, 32'hCAFEF00D));
        vecs.push_back(mk(0, 2'b00, 0, 32'h53, 32'h0,        32'h000000CA, 0, -1, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h51, 32'h0,        32'hFFFFFFF0, 0, -1, 32'h0));
`ifdef LSU_TRAP_DESALINHADO_EN
        vecs.push_back(mk(0, 2'b10, 0, 32'h05, 32'h0,        32'h0,        1, -1, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h07, 32'h0000BEEF, 32'h0,        1, 1,  32'h11AA3344));
`else
        vecs.push_back(mk(0, 2'b10, 0, 32'h05, 32'h0,        32'h11AA3344, 0, -1, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h07, 32'h0000BEEF, 32'h0,        0, 1,  32'hBEEF3344));
`endif

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        mem_clear = 1'b0;
        #1;
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_erro", {31'h0, bus.resp_erro}, 32'h0);
        chk("rst_resp_dado", bus.resp_dado, 32'h0);
        chk("rst_mem_controle", {31'h0, bus.mem_controle}, 32'h0);
        chk("rst_mem_endereco", bus.mem_endereco, 32'h0);
        chk("rst_mem_dado_wrt", bus.mem_dado_wrt, 32'h0);

        foreach (vecs[k]) do_req(vecs[k], k);

        // Reset dropped while the store sits in ESCRITA: nothing may reach memory.
        for (int c = 0; c < 8 && !bus.req_ready; c++) @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_escrita  = 1'b1;
        bus.req_tamanho  = 2'b10;
        bus.req_sinal    = 1'b0;
        bus.req_endereco = 32'h0;
        bus.req_dado     = 32'h12345678;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        chk("abort_escrita_we", {31'h0, bus.mem_controle}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort_we_gated", {31'h0, bus.mem_controle}, 32'h0);
        @(posedge clock); #1;
        chk("abort_no_resp", {31'h0, bus.resp_valid}, 32'h0);
        chk("abort_mem", mem[0], 32'h80010000);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("abort_ready", {31'h0, bus.req_ready}, 32'h1);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clock); #1;
                if (bus.resp_valid) seen++;
            end
            chk("abort_resp_count", seen, 0);
        end
        chk("abort_mem_after", mem[0], 32'h80010000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
